pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register carrying a control field and data payload between
// two CPU stages over a valid/ready handshake. Control is forced to zero on
// a bubble, so an empty stage always presents as a NOP downstream. An
// optional skid entry registers the backpressure path, and a saturating
// counter records stall cycles.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 101,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [DATA_W-1:0] dn_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FULL     = 2'd1,
    ST_SKIDFULL = 2'd2
  } state_t;

  state_t            r_state;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [DATA_W-1:0] r_s_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_dn_valid;
  logic w_up_ready;
  logic w_accept;
  logic w_pop;

  assign w_dn_valid = (r_state != ST_EMPTY);
  assign w_accept   = up_valid & w_up_ready;
  assign w_pop      = w_dn_valid & dn_ready;

  // Ready: with a skid entry it decodes only registered state (no path from
  // dn_ready); without one it passes dn_ready through when holding a beat.
  // Held low while reset is asserted in both configurations.
  always_comb begin
    w_up_ready = 1'b0;
    if (SKID != 0) begin
      w_up_ready = !cpu_rst && (r_state != ST_SKIDFULL);
    end else begin
      w_up_ready = !cpu_rst && ((r_state == ST_EMPTY) || dn_ready);
    end
  end

  // Occupancy FSM and storage; flush wins over any accept or pop.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state  <= ST_EMPTY;
      r_m_ctrl <= '0;
      r_m_data <= '0;
      r_s_ctrl <= '0;
      r_s_data <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_m_ctrl <= up_ctrl;
            r_m_data <= up_data;
            r_state  <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (w_accept && w_pop) begin
            r_m_ctrl <= up_ctrl;
            r_m_data <= up_data;
          end else if (w_pop) begin
            r_state <= ST_EMPTY;
          end else if (w_accept && (SKID != 0)) begin
            // Main entry is still stalled downstream: park the new beat in S
            // so it leaves strictly after M.
            r_s_ctrl <= up_ctrl;
            r_s_data <= up_data;
            r_state  <= ST_SKIDFULL;
          end
        end
        ST_SKIDFULL: begin
          if (w_pop) begin
            r_m_ctrl <= r_s_ctrl;
            r_m_data <= r_s_data;
            r_state  <= ST_FULL;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where a valid beat is held back downstream.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_stall_cnt <= '0;
    end else if (w_dn_valid && !dn_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign up_ready  = w_up_ready;
  assign dn_valid  = w_dn_valid;
  assign dn_ctrl   = w_dn_valid ? r_m_ctrl : '0;
  assign dn_data   = r_m_data;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (defaults), a single-entry
// instance, and a 4-bit-counter instance, checked with a vector table,
// per-instance occupancy models with expected-beat queues, and hand sequences.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 101;

  typedef struct packed {
    logic [7:0]    c;
    logic [DW-1:0] d;
  } beat_t;

  typedef struct {
    logic       uv;
    logic [7:0] d;
    logic [7:0] c;
    logic       fl;
    logic       dr;
    logic       ev;
    logic [7:0] ed;
    logic       er;
    logic [15:0] es;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  // Instance A: SKID=1, CNT_W=16
  logic fl, uv, ur, dv, dr;
  logic [7:0] uc, dc;
  logic [DW-1:0] ud, dd;
  logic [15:0] sc;
  // Instance B: SKID=0
  logic fl0, uv0, ur0, dv0, dr0;
  logic [7:0] uc0, dc0;
  logic [DW-1:0] ud0, dd0;
  logic [15:0] sc0;
  // Instance C: CNT_W=4
  logic flc, uvc, urc, dvc, drc;
  logic [7:0] ucc, dcc;
  logic [DW-1:0] udc, ddc;
  logic [3:0] scc;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(DW), .SKID(1), .CNT_W(16)) dut (
    .cpu_clk_50M(clk), .cpu_rst(rst), .flush(fl), .up_valid(uv), .up_ready(ur),
    .up_ctrl(uc), .up_data(ud), .dn_valid(dv), .dn_ready(dr), .dn_ctrl(dc),
    .dn_data(dd), .stall_cnt(sc));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(DW), .SKID(0), .CNT_W(16)) dut0 (
    .cpu_clk_50M(clk), .cpu_rst(rst), .flush(fl0), .up_valid(uv0), .up_ready(ur0),
    .up_ctrl(uc0), .up_data(ud0), .dn_valid(dv0), .dn_ready(dr0), .dn_ctrl(dc0),
    .dn_data(dd0), .stall_cnt(sc0));

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(DW), .SKID(1), .CNT_W(4)) dutc (
    .cpu_clk_50M(clk), .cpu_rst(rst), .flush(flc), .up_valid(uvc), .up_ready(urc),
    .up_ctrl(ucc), .up_data(udc), .dn_valid(dvc), .dn_ready(drc), .dn_ctrl(dcc),
    .dn_data(ddc), .stall_cnt(scc));

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  beat_t q[$];
  beat_t q0[$];
  int unsigned m_stall  = 0;
  int unsigned m_stall0 = 0;
  vec_t tbl[25];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic uv_i, input logic [7:0] d_i, input logic [7:0] c_i,
                              input logic fl_i, input logic dr_i, input logic ev_i,
                              input logic [7:0] ed_i, input logic er_i, input logic [15:0] es_i);
    vec_t v;
    v.uv = uv_i; v.d = d_i; v.c = c_i; v.fl = fl_i; v.dr = dr_i;
    v.ev = ev_i; v.ed = ed_i; v.er = er_i; v.es = es_i;
    return v;
  endfunction

  // Checks instance A against the occupancy model, then advances the model
  // by the handshakes of the current cycle. Called after inputs settle.
  task automatic sb_main();
    logic mv, mr;
    mv = (q.size() != 0);
    mr = !rst && (q.size() < 2);
    chk("a_valid", dv, mv);
    chk("a_ready", ur, mr);
    chk("a_stall", sc, m_stall);
    if (mv) begin
      chk("a_data", dd, q[0].d);
      chk("a_ctrl", dc, q[0].c);
    end else begin
      chk("a_ctrl_bubble", dc, 0);
    end
    if (mv && !dr && m_stall < 65535) m_stall++;
    if (fl) begin
      q.delete();
    end else begin
      if (mv && dr) void'(q.pop_front());
      if (uv && mr) q.push_back('{c: uc, d: ud});
    end
  endtask

  task automatic sb_b();
    logic mv, mr;
    mv = (q0.size() != 0);
    mr = !rst && (!mv || dr0);
    chk("b_valid", dv0, mv);
    chk("b_ready", ur0, mr);
    chk("b_stall", sc0, m_stall0);
    if (mv) begin
      chk("b_data", dd0, q0[0].d);
      chk("b_ctrl", dc0, q0[0].c);
    end else begin
      chk("b_ctrl_bubble", dc0, 0);
    end
    if (mv && !dr0) m_stall0++;
    if (mv && dr0) void'(q0.pop_front());
    if (uv0 && mr) q0.push_back('{c: uc0, d: ud0});
  endtask

  initial begin
    fl = 0; uv = 0; uc = '0; ud = '0; dr = 1;
    fl0 = 0; uv0 = 0; uc0 = '0; ud0 = '0; dr0 = 1;
    flc = 0; uvc = 0; ucc = '0; udc = '0; drc = 1;

    // Streaming 1..8, ctrl A5, no backpressure
    for (int k = 0; k < 9; k++)
      tbl[k] = mk(k < 8, 8'(k + 1), 8'hA5, 1'b0, 1'b1, k >= 1, 8'(k), 1'b1, 16'd0);
    // Skid backpressure: stream 1,2,3, dn_ready low for 3 cycles
    tbl[9]  = mk(1'b1, 8'd1, 8'h3C, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 16'd0);
    tbl[10] = mk(1'b1, 8'd2, 8'h3C, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 16'd0);
    tbl[11] = mk(1'b1, 8'd3, 8'h3C, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 16'd1);
    tbl[12] = mk(1'b1, 8'd3, 8'h3C, 1'b0, 1'b0, 1'b1, 8'd1, 1'b0, 16'd2);
    tbl[13] = mk(1'b1, 8'd3, 8'h3C, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 16'd3);
    tbl[14] = mk(1'b1, 8'd3, 8'h3C, 1'b0, 1'b1, 1'b1, 8'd2, 1'b1, 16'd3);
    tbl[15] = mk(1'b0, 8'd0, 8'h3C, 1'b0, 1'b1, 1'b1, 8'd3, 1'b1, 16'd3);
    tbl[16] = mk(1'b0, 8'd0, 8'h3C, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 16'd3);
    // Flush from SKIDFULL (beat 9 offered), then flush from FULL with accept
    tbl[17] = mk(1'b1, 8'd10, 8'h5A, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 16'd3);
    tbl[18] = mk(1'b1, 8'd11, 8'h5A, 1'b0, 1'b0, 1'b1, 8'd10, 1'b1, 16'd3);
    tbl[19] = mk(1'b1, 8'd9,  8'h5A, 1'b1, 1'b1, 1'b1, 8'd10, 1'b0, 16'd4);
    tbl[20] = mk(1'b0, 8'd0,  8'h5A, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 16'd4);
    tbl[21] = mk(1'b1, 8'd12, 8'h5A, 1'b0, 1'b0, 1'b0, 8'd0,  1'b1, 16'd4);
    tbl[22] = mk(1'b1, 8'd9,  8'h5A, 1'b1, 1'b0, 1'b1, 8'd12, 1'b1, 16'd4);
    tbl[23] = mk(1'b0, 8'd0,  8'h5A, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 16'd5);
    tbl[24] = mk(1'b0, 8'd0,  8'h5A, 1'b0, 1'b1, 1'b0, 8'd0,  1'b1, 16'd5);

    // Initial reset
    #5 rst = 1;
    #2;
    chk("rst_valid", dv, 0); chk("rst_ctrl", dc, 0); chk("rst_data", dd, 0);
    chk("rst_stall", sc, 0); chk("rst_ready", ur, 0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("rst_rel_ready_a", ur, 1);
    chk("rst_rel_ready_b", ur0, 1);
    chk("rst_rel_ready_c", urc, 1);

    // Table: streaming, skid, flush on instance A
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      uv = tbl[i].uv; uc = tbl[i].c; fl = tbl[i].fl; dr = tbl[i].dr;
      ud = '0; ud[7:0] = tbl[i].d;
      #1;
      chk($sformatf("t_valid[%0d]", i), dv, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("t_data[%0d]", i), dd, tbl[i].ed);
      else           chk($sformatf("t_ctrl0[%0d]", i), dc, 0);
      chk($sformatf("t_ready[%0d]", i), ur, tbl[i].er);
      chk($sformatf("t_stall[%0d]", i), sc, tbl[i].es);
      sb_main();
    end
    @(negedge clk); uv = 0; fl = 0; dr = 1;

    // Single-entry stage: dn_ready toggles while full, up_ready follows it
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      uv0 = (k < 10); uc0 = 8'hC3; ud0 = DW'(100 + k);
      dr0 = (k == 11) ? 1'b1 : k[0];
      #1;
      if (k >= 1 && k < 10) chk($sformatf("b_mirror[%0d]", k), ur0, dr0);
      sb_b();
    end
    chk("b_stall_total", sc0, 5);

    // Saturation on the 4-bit counter
    @(negedge clk); uvc = 1; ucc = 8'h11; udc = DW'(7); drc = 0;
    @(negedge clk); uvc = 0;
    for (int n = 0; n < 20; n++) begin
      #1;
      chk($sformatf("c_valid[%0d]", n), dvc, 1);
      chk($sformatf("c_data[%0d]", n), ddc, 7);
      chk($sformatf("c_stall[%0d]", n), scc, (n > 15) ? 15 : n);
      @(negedge clk);
    end
    chk("c_sat_final", scc, 15);

    // Mid-stream asynchronous reset with beats held in both entries
    uv = 1; uc = 8'h77; ud = DW'(20); dr = 0;
    @(negedge clk); ud = DW'(21);
    @(negedge clk); uv = 0;
    #3 rst = 1;
    #1;
    chk("mrst_valid", dv, 0); chk("mrst_ctrl", dc, 0); chk("mrst_data", dd, 0);
    chk("mrst_stall", sc, 0); chk("mrst_ready", ur, 0);
    chk("mrst_c_stall", scc, 0); chk("mrst_b_valid", dv0, 0);
    @(negedge clk);
    chk("mrst_hold_valid", dv, 0); chk("mrst_hold_ready", ur, 0);
    rst = 0; dr = 1;
    q.delete(); m_stall = 0;
    @(posedge clk); #1;
    chk("mrst_rel_ready", ur, 1);
    chk("mrst_rel_valid", dv, 0);
    chk("mrst_rel_stall", sc, 0);
    @(negedge clk);
    uv = 1; uc = 8'h42; ud = DW'(33);
    #1 sb_main();
    @(negedge clk); uv = 0;
    #1 sb_main();
    @(negedge clk);
    #1 sb_main();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
